// File: rtl/pooling_param.sv
// pooling_param: 2x2 stride-2 max/average pooling over a raster pixel stream.
// A one-row line buffer holds horizontal pair results until the odd row completes each window.
module pooling_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int IMG_W  = 4,
  parameter int IMG_H  = 4,
  parameter bit SIGNED = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode_i,
  input  logic              act_valid_i,
  input  logic              act_last_i,
  input  logic [DATA_W-1:0] act_result_i,
  input  logic [ADDR_W-1:0] act_result_address_i,
  output logic [DATA_W-1:0] pool_result_o,
  output logic [ADDR_W-1:0] pool_result_address_o,
  output logic              pool_valid_o,
  output logic              pool_last_o,
  output logic              pool_err_o
);
  localparam int PW = DATA_W + 2;
  localparam int CW = IMG_W > 2 ? $clog2(IMG_W) : 1;
  localparam int RW = IMG_H > 2 ? $clog2(IMG_H) : 1;
  localparam int NB = IMG_W / 2;
  localparam int HW = NB > 1 ? $clog2(NB) : 1;

  function automatic logic [PW-1:0] ext(input logic [DATA_W-1:0] v);
    return SIGNED ? {{2{v[DATA_W-1]}}, v} : {2'b00, v};
  endfunction

  function automatic logic gt(input logic [PW-1:0] a, input logic [PW-1:0] b);
    return SIGNED ? ($signed(a) > $signed(b)) : (a > b);
  endfunction

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] h_q, h_d;
  logic [PW-1:0]     buf_q [NB];
  logic [PW-1:0]     buf_d [NB];
  logic [DATA_W-1:0] res_q, res_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d, last_q, last_d, err_q, err_d;
  logic              end_col, end_row, fin, abort;
  logic [HW-1:0]     hc;
  logic [PW-1:0]     xe, he, p, b, s, avg, win;
  logic signed [PW-1:0] ss;
  logic              addr_unused;

  assign addr_unused = ^act_result_address_i;

  always_comb begin
    end_col = col_q == CW'(IMG_W - 1);
    end_row = row_q == RW'(IMG_H - 1);
    fin     = end_col && end_row;
    abort   = act_valid_i && act_last_i && !fin;
    hc      = HW'(col_q >> 1);
    xe      = ext(act_result_i);
    he      = ext(h_q);
    p       = mode_q ? he + xe : (gt(xe, he) ? xe : he);
    b       = buf_q[hc];
    s       = p + b;
    // Sum of four pixels always fits PW bits, so the shifted value fits DATA_W.
    ss      = $signed(s) >>> 2;
    avg     = SIGNED ? $unsigned(ss) : s >> 2;
    win     = mode_q ? avg : (gt(p, b) ? p : b);
  end

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    h_d     = h_q;
    buf_d   = buf_q;
    res_d   = res_q;
    addr_d  = addr_q;
    valid_d = 1'b0;
    last_d  = 1'b0;
    err_d   = 1'b0;
    mode_d  = (act_valid_i && col_q == '0 && row_q == '0) ? mode_i : mode_q;
    if (act_valid_i && abort) begin
      col_d = '0;
      row_d = '0;
      err_d = 1'b1;
    end else if (act_valid_i) begin
      col_d = end_col ? '0 : col_q + CW'(1);
      row_d = end_col ? (end_row ? '0 : row_q + RW'(1)) : row_q;
      if (!col_q[0]) h_d = act_result_i;
      else if (!row_q[0]) buf_d[hc] = p;
      else begin
        valid_d = 1'b1;
        last_d  = fin;
        res_d   = win[DATA_W-1:0];
        addr_d  = ADDR_W'(32'(row_q >> 1) * (IMG_W / 2) + 32'(col_q >> 1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col_q   <= '0;
      row_q   <= '0;
      mode_q  <= 1'b0;
      h_q     <= '0;
      res_q   <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      mode_q  <= mode_d;
      h_q     <= h_d;
      res_q   <= res_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // Line buffer is never cleared: each entry is rewritten on an even row before use.
  always_ff @(posedge clk) buf_q <= buf_d;

  assign pool_result_o         = res_q;
  assign pool_result_address_o = addr_q;
  assign pool_valid_o          = valid_q;
  assign pool_last_o           = last_q;
  assign pool_err_o            = err_q;
endmodule
